// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer around a single 1-bit full adder.
// Operands are latched on Start and fed LSB-first; results publish with Done.
module serial_adder_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_Start,
   input  logic             i_Sub,
   input  logic [WIDTH-1:0] i_OpA,
   input  logic [WIDTH-1:0] i_OpB,
   output logic             o_Busy,
   output logic             o_Done,
   output logic [WIDTH-1:0] o_Sum,
   output logic             o_Cout,
   output logic             o_Overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sh;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cmsb;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic             w_s;
   logic             w_c;
   logic             w_last;

   // One-bit full adder on the current LSBs and the registered carry
   always_comb begin
      w_s    = r_a[0] ^ r_b[0] ^ r_carry;
      w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
      w_last = (r_cnt == CW'(WIDTH - 1));
   end

   // Sequencer FSM with registered status and result outputs
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sh    <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cmsb  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_Start) begin
                  r_a     <= i_OpA;
                  r_b     <= i_Sub ? ~i_OpB : i_OpB;
                  r_carry <= i_Sub;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_carry <= w_c;
               r_sh    <= {w_s, r_sh[WIDTH-1:1]};
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  // carry into the MSB, kept for signed overflow
                  r_cmsb  <= r_carry;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_sum   <= r_sh;
               r_cout  <= r_carry;
               r_ovf   <= r_cmsb ^ r_carry;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_Busy     = r_busy;
   assign o_Done     = r_done;
   assign o_Sum      = r_sum;
   assign o_Cout     = r_cout;
   assign o_Overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=4).
// Table vectors, multi-cycle corner sequences and an exhaustive sweep.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       sub_i = 1'b0;
   logic [3:0] opa = '0;
   logic [3:0] opb = '0;
   logic       busy;
   logic       done;
   logic [3:0] sum;
   logic       cout;
   logic       ovf;

   int total = 0;
   int passed = 0;
   int failed = 0;

   serial_adder_ctrl #(.WIDTH(4)) dut (
      .i_Clk      (clk),
      .i_Reset    (rst),
      .i_Start    (start),
      .i_Sub      (sub_i),
      .i_OpA      (opa),
      .i_OpB      (opb),
      .o_Busy     (busy),
      .o_Done     (done),
      .o_Sum      (sum),
      .o_Cout     (cout),
      .o_Overflow (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       sub;
      logic [3:0] s;
      logic       c;
      logic       v;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic sub);
      logic [4:0] t;
      logic [3:0] bb;
      logic       v;
      bb = sub ? ~b : b;
      t  = {1'b0, a} + {1'b0, bb} + {4'b0, sub};
      if (sub) v = (a[3] != b[3]) && (t[3] != a[3]);
      else     v = (a[3] == b[3]) && (t[3] != a[3]);
      return {t[3:0], t[4], v};
   endfunction

   // Start one op, scramble operands after the Start edge, wait for Done.
   task automatic run_op(input string nm, input logic [3:0] a, input logic [3:0] b,
                         input logic sub, input logic [3:0] es, input logic ec,
                         input logic ev);
      logic [3:0] prev;
      int  k;
      bit  got;
      bit  bad;
      bit  b1;
      @(negedge clk);
      prev  = sum;
      opa   = a;
      opb   = b;
      sub_i = sub;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      opa   = ~a;
      opb   = a ^ b;
      sub_i = ~sub;
      b1    = busy;
      bad   = 1'b0;
      got   = 1'b0;
      k     = 0;
      while (!got && k < 20) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         if (done) got = 1'b1;
         else if (busy && sum !== prev) bad = 1'b1;
      end
      chk({nm, "_latency"}, k, 5);
      chk({nm, "_result"}, {sum, cout, ovf}, {es, ec, ev});
      chk({nm, "_busy"}, b1, 1);
      chk({nm, "_stable"}, bad, 0);
      @(negedge clk);
      chk({nm, "_pulse"}, done, 0);
   endtask

   initial begin
      int k;
      int nd;
      int dn[8];
      logic [5:0] m;

      vecs[0] = '{4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 1'b1};
      vecs[1] = '{4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0};
      vecs[2] = '{4'd0,  4'd0, 1'b0, 4'd0,  1'b0, 1'b0};
      vecs[3] = '{4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
      vecs[4] = '{4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
      vecs[5] = '{4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
      vecs[6] = '{4'd5,  4'd5, 1'b1, 4'd0,  1'b1, 1'b0};
      vecs[7] = '{4'd0,  4'd1, 1'b1, 4'd15, 1'b0, 1'b0};
      vecs[8] = '{4'd8,  4'd8, 1'b0, 4'd0,  1'b1, 1'b1};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {busy, done, sum, cout, ovf}, 8'h00);
      rst = 1'b0;

      for (int i = 0; i < 9; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                vecs[i].s, vecs[i].c, vecs[i].v);

      // Second Start two cycles into an op is ignored
      @(negedge clk);
      opa = 4'd2; opb = 4'd3; sub_i = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      opa = 4'd9; opb = 4'd9; sub_i = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 2;
      while (!done && k < 20) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      chk("ign_latency", k, 5);
      chk("ign_result", {sum, cout, ovf}, {4'd5, 1'b0, 1'b0});
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("ign_no_extra_done", nd, 0);

      // Start held high: back-to-back ops every 6 cycles
      @(negedge clk);
      opa = 4'd1; opb = 4'd1; sub_i = 1'b0; start = 1'b1;
      nd = 0;
      for (int c = 1; c <= 26; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done && nd < 8) begin
            dn[nd] = c;
            nd++;
         end
      end
      start = 1'b0;
      chk("held_count", nd, 4);
      chk("held_first", dn[0], 6);
      chk("held_gap1", dn[1] - dn[0], 6);
      chk("held_gap3", dn[3] - dn[2], 6);
      chk("held_sum", sum, 4'd2);
      repeat (10) @(negedge clk);

      // Reset two cycles into SHIFT aborts without Done
      @(negedge clk);
      opa = 4'd7; opb = 4'd7; sub_i = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_state", {busy, done, sum, cout, ovf}, 8'h00);
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      chk("abort_quiet", nd, 0);
      run_op("after_abort", 4'd7, 4'd7, 1'b0, 4'd14, 1'b0, 1'b1);

      // Exhaustive sweep against the reference model
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
               m = model(4'(a), 4'(b), 1'(s));
               run_op($sformatf("ex_%0d_%0d_%0d", s, a, b), 4'(a), 4'(b), 1'(s),
                      m[5:2], m[1], m[0]);
            end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
